// File: rtl/fib_gpio_driver_if.sv
// Wishbone slave bus bundle for fib_gpio_driver.
// Signal names match the Caravel user-project Wishbone ports.
interface fib_gpio_driver_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fib_gpio_driver.sv
// Fibonacci pattern generator on the low eight user pads, configured over
// Wishbone: CTRL (EN/OE/STOP_ON_OVF/RESTART), PERIOD, VALUE and STEPS.
module fib_gpio_driver #(
    parameter logic [31:0]          BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned          PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = 24'd1000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    fib_gpio_driver_if.slave       bus,
    output logic [7:0]             io_out,
    output logic [7:0]             io_oeb
);

    // LAST: a holds 233 and the next advance overflows; DONE: halted on 233.
    typedef enum logic [1:0] {
        ST_SEQ,
        ST_LAST,
        ST_DONE
    } seq_state_t;

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    seq_state_t          state, state_n;
    logic [7:0]          a, a_n;
    logic [7:0]          b, b_n;
    logic [PERIOD_W-1:0] timer, timer_n;
    logic [15:0]         steps, steps_n;

    logic                en, oe, stop;
    logic [PERIOD_W-1:0] period;

    logic                access, hit, wr, ctrl_wr, period_wr, restart;
    logic [1:0]          off;
    logic [31:0]         be_mask;
    logic [31:0]         rdata;
    logic [PERIOD_W-1:0] p_eff;
    logic                term;
    logic [8:0]          sum;
    logic [15:0]         steps_inc;
    logic                last, done;

    assign access    = bus.wbs_stb_i & bus.wbs_cyc_i & ~bus.wbs_ack_o;
    assign hit       = (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off       = bus.wbs_adr_i[3:2];
    assign wr        = access & bus.wbs_we_i & hit;
    assign ctrl_wr   = wr && (off == 2'd0) && bus.wbs_sel_i[0];
    assign period_wr = wr && (off == 2'd1);
    assign restart   = ctrl_wr & bus.wbs_dat_i[3];
    assign be_mask   = {{8{bus.wbs_sel_i[3]}}, {8{bus.wbs_sel_i[2]}},
                        {8{bus.wbs_sel_i[1]}}, {8{bus.wbs_sel_i[0]}}};

    assign last = (state != ST_SEQ);
    assign done = (state == ST_DONE);

    assign p_eff     = (period == '0) ? ONE : period;
    assign term      = (timer >= p_eff - ONE);
    assign sum       = {1'b0, a} + {1'b0, b};
    assign steps_inc = (steps == '1) ? steps : steps + 16'd1;

    assign io_out = a;
    assign io_oeb = oe ? '0 : '1;

    // Configuration registers with byte-lane write enables.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en     <= 1'b0;
            oe     <= 1'b0;
            stop   <= 1'b0;
            period <= DEFAULT_PERIOD;
        end else begin
            if (ctrl_wr) begin
                en   <= bus.wbs_dat_i[0];
                oe   <= bus.wbs_dat_i[1];
                stop <= bus.wbs_dat_i[2];
            end
            if (period_wr) begin
                period <= (period & ~be_mask[PERIOD_W-1:0]) |
                          (bus.wbs_dat_i[PERIOD_W-1:0] & be_mask[PERIOD_W-1:0]);
            end
        end
    end

    // Read data multiplexer; unmapped addresses return zero.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                2'd0: rdata[2:0] = {stop, oe, en};
                2'd1: rdata[PERIOD_W-1:0] = period;
                2'd2: rdata[17:0] = {done, last, b, a};
                default: rdata[15:0] = steps;
            endcase
        end
    end

    // Single-cycle registered ack; read data is zero whenever ack is low.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
        end else begin
            bus.wbs_ack_o <= access;
            bus.wbs_dat_o <= access ? rdata : '0;
        end
    end

    // Sequencer next state: restart has priority over a coincident advance.
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        timer_n = timer;
        steps_n = steps;
        if (restart) begin
            state_n = ST_SEQ;
            a_n     = '0;
            b_n     = 8'd1;
            timer_n = '0;
            steps_n = '0;
        end else if (en && (state != ST_DONE)) begin
            if (term) begin
                timer_n = '0;
                case (state)
                    ST_SEQ: begin
                        a_n     = b;
                        steps_n = steps_inc;
                        if (sum[8]) begin
                            state_n = ST_LAST;
                        end else begin
                            b_n = sum[7:0];
                        end
                    end
                    ST_LAST: begin
                        if (stop) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_SEQ;
                            a_n     = '0;
                            b_n     = 8'd1;
                            steps_n = steps_inc;
                        end
                    end
                    default: ;
                endcase
            end else begin
                timer_n = timer + ONE;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_SEQ;
            a     <= '0;
            b     <= 8'd1;
            timer <= '0;
            steps <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            timer <= timer_n;
            steps <= steps_n;
        end
    end

endmodule

// File: tb/tb_fib_gpio_driver.sv
// Self-checking bench for fib_gpio_driver: directed scenarios plus randomized
// period/policy runs against a time-based model of the sequence.
module tb_fib_gpio_driver;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] A_CTL = BASE + 32'h0;
    localparam logic [31:0] A_PER = BASE + 32'h4;
    localparam logic [31:0] A_VAL = BASE + 32'h8;
    localparam logic [31:0] A_STP = BASE + 32'hC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] io_out, io_oeb;
    int unsigned cycle = 0;
    int checks = 0;
    int failures = 0;

    int unsigned fib [14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    logic [7:0] hist [0:255];
    logic [7:0] seen [$];

    fib_gpio_driver_if bus ();

    fib_gpio_driver #(
        .BASE_ADDR(32'h3000_0000),
        .PERIOD_W(24),
        .DEFAULT_PERIOD(24'd1000)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus.slave),
        .io_out(io_out),
        .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge N settles, cycle == N.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: after k edges from the EN/RESTART edge, n = k / max(P,1) advances.
    function automatic int unsigned n_adv(int unsigned k, int unsigned p);
        return k / ((p == 0) ? 1 : p);
    endfunction

    function automatic int unsigned seq_idx(int unsigned k, int unsigned p, bit stop);
        int unsigned n = n_adv(k, p);
        if (stop) return (n > 13) ? 13 : n;
        return n % 14;
    endfunction

    function automatic int unsigned exp_a(int unsigned k, int unsigned p, bit stop);
        return fib[seq_idx(k, p, stop)];
    endfunction

    function automatic logic [31:0] exp_value(int unsigned k, int unsigned p, bit stop);
        int unsigned i = seq_idx(k, p, stop);
        int unsigned bv = (i < 13) ? fib[i + 1] : 233;
        logic dn = stop && (n_adv(k, p) >= 14);
        logic ls = (i == 13);
        return {14'd0, dn, ls, bv[7:0], fib[i][7:0]};
    endfunction

    function automatic int unsigned exp_steps(int unsigned k, int unsigned p, bit stop);
        int unsigned n = n_adv(k, p);
        if (stop) return (n > 13) ? 13 : n;
        return (n > 65535) ? 65535 : n;
    endfunction

    task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output int unsigned edge_idx);
        int unsigned n = 0;
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.wbs_ack_o && n < 4);
        check_eq("ack", 32'(bus.wbs_ack_o), 32'd1);
        edge_idx = cycle;
        rd = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output int unsigned e);
        logic [31:0] rd;
        wb_xfer(1'b1, adr, dat, sel, rd, e);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd, output int unsigned c);
        wb_xfer(1'b0, adr, 32'd0, 4'hF, rd, c);
    endtask

    task automatic run_seq(input int unsigned e, input int unsigned p, input bit stop,
                           input int unsigned ncyc);
        int unsigned k;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            k = cycle - e;
            check_eq("io_out", 32'(io_out), exp_a(k, p, stop));
            if (k < 256) hist[k] = io_out;
            if ((io_out == 8'd5 || io_out == 8'd55 || io_out == 8'd144) &&
                (seen.size() == 0 || seen[$] != io_out))
                seen.push_back(io_out);
        end
    endtask

    task automatic wait_io(input logic [7:0] v, input int unsigned limit);
        int unsigned n = 0;
        while (io_out != v && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("wait_io", 32'(io_out), 32'(v));
    endtask

    task automatic check_reset_regs(input string tag);
        logic [31:0] rd;
        int unsigned c;
        check_eq({tag, "_io_out"}, 32'(io_out), 32'd0);
        check_eq({tag, "_io_oeb"}, 32'(io_oeb), 32'hFF);
        wb_read(A_CTL, rd, c); check_eq({tag, "_ctrl"}, rd, 32'd0);
        wb_read(A_PER, rd, c); check_eq({tag, "_period"}, rd, 32'd1000);
        wb_read(A_VAL, rd, c); check_eq({tag, "_value"}, rd, 32'h0000_0100);
        wb_read(A_STP, rd, c); check_eq({tag, "_steps"}, rd, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned e, e2, c, p, ncyc, fz;
        bit stop;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;

        // 1: reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check_eq("rst_dat", bus.wbs_dat_o, 32'd0);
        check_reset_regs("reset");

        // 2: run with wrap policy, milestones in order
        wb_write(A_PER, 32'd4, 4'hF, e);
        seen.delete();
        wb_write(A_CTL, 32'd3, 4'hF, e);
        check_eq("oeb_on", 32'(io_oeb), 32'd0);
        run_seq(e, 4, 1'b0, 52);
        check_eq("t20", 32'(hist[20]), 32'd5);
        check_eq("t40", 32'(hist[40]), 32'd55);
        check_eq("t48", 32'(hist[48]), 32'd144);
        check_eq("t52", 32'(hist[52]), 32'd233);
        check_eq("ms_count", seen.size(), 32'd3);
        if (seen.size() >= 3) begin
            check_eq("ms0", 32'(seen[0]), 32'd5);
            check_eq("ms1", 32'(seen[1]), 32'd55);
            check_eq("ms2", 32'(seen[2]), 32'd144);
        end

        // 3: stop on overflow
        do_reset();
        wb_write(A_PER, 32'd4, 4'hF, e);
        wb_write(A_CTL, 32'd7, 4'hF, e);
        run_seq(e, 4, 1'b1, 156);
        check_eq("stop_t56", 32'(hist[56]), 32'd233);
        check_eq("stop_t156", 32'(hist[156]), 32'd233);
        wb_read(A_VAL, rd, c);
        check_eq("stop_value", rd, exp_value(c - 1 - e, 4, 1'b1));
        check_eq("stop_done", 32'(rd[17]), 32'd1);
        wb_read(A_STP, rd, c);
        check_eq("stop_steps", rd, 32'd13);

        // 4: wrap after 233
        do_reset();
        wb_write(A_PER, 32'd4, 4'hF, e);
        wb_write(A_CTL, 32'd3, 4'hF, e);
        run_seq(e, 4, 1'b0, 61);
        check_eq("wrap_t55", 32'(hist[55]), 32'd233);
        check_eq("wrap_t56", 32'(hist[56]), 32'd0);
        check_eq("wrap_t60", 32'(hist[60]), 32'd1);
        wb_read(A_VAL, rd, c);
        check_eq("wrap_value", rd, exp_value(c - 1 - e, 4, 1'b0));
        wb_read(A_STP, rd, c);
        check_eq("wrap_steps", rd, exp_steps(c - 1 - e, 4, 1'b0));

        // 5: restart mid-run, back-to-back strobes, byte-lane write, decode
        wait_io(8'd21, 100);
        wb_write(A_CTL, 32'hB, 4'hF, e);
        check_eq("restart_io", 32'(io_out), 32'd0);
        wb_read(A_STP, rd, c);
        check_eq("restart_steps", rd, exp_steps(c - 1 - e, 4, 1'b0));
        run_seq(e, 4, 1'b0, 30);
        @(posedge clk);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = A_CTL;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("b2b_ack", 32'(bus.wbs_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (bus.wbs_ack_o) check_eq("b2b_rd", bus.wbs_dat_o, 32'd3);
            else check_eq("b2b_dat0", bus.wbs_dat_o, 32'd0);
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        wb_write(A_CTL, 32'd0, 4'hF, e);
        wb_write(A_PER, 32'h0012_3456, 4'hF, e);
        wb_write(A_PER, 32'hFFFF_FF02, 4'b0001, e);
        wb_read(A_PER, rd, c);
        check_eq("sel_period", rd, 32'h0012_3402);
        wb_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, e);
        wb_read(BASE + 32'h10, rd, c);
        check_eq("unmapped_rd", rd, 32'd0);
        wb_write(32'h4000_0000, 32'hF, 4'hF, e);
        wb_read(A_CTL, rd, c);
        check_eq("foreign_wr", rd, 32'd0);

        // Randomized period / policy runs
        for (int it = 0; it < 8; it++) begin
            p    = $urandom_range(0, 5);
            stop = 1'($urandom_range(0, 1));
            ncyc = $urandom_range(10, 120);
            wb_write(A_PER, p, 4'hF, e);
            wb_write(A_CTL, 32'hB | (32'(stop) << 2), 4'hF, e);
            run_seq(e, p, stop, ncyc);
            wb_read(A_VAL, rd, c);
            check_eq("rnd_value", rd, exp_value(c - 1 - e, p, stop));
            wb_read(A_STP, rd, c);
            check_eq("rnd_steps", rd, exp_steps(c - 1 - e, p, stop));
            check_eq("rnd_oeb", 32'(io_oeb), 32'd0);
        end

        // EN=0 freezes the sequence
        wb_write(A_PER, 32'd3, 4'hF, e);
        wb_write(A_CTL, 32'hB, 4'hF, e);
        run_seq(e, 3, 1'b0, 7);
        wb_write(A_CTL, 32'd0, 4'hF, e2);
        fz = exp_a(e2 - e, 3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("freeze_io", 32'(io_out), fz);
        check_eq("freeze_oeb", 32'(io_oeb), 32'hFF);
        wb_read(A_STP, rd, c);
        check_eq("freeze_steps", rd, exp_steps(e2 - e, 3, 1'b0));

        // 6: reset mid-run with an ack pending
        wb_write(A_PER, 32'd4, 4'hF, e);
        wb_write(A_CTL, 32'hB, 4'hF, e);
        wait_io(8'd89, 200);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = A_STP;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        check_eq("midrst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check_eq("midrst_dat", bus.wbs_dat_o, 32'd0);
        check_reset_regs("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fib_gpio_driver.md
Name: fib_gpio_driver

Overview:
Wishbone-slave user-project block that produces the 8-bit Fibonacci sequence 0,1,1,2,3,5,…,233 on mprj_io[7:0]. The off-chip monitor watches for the milestones 5, 55 and 144 on those pins. Firmware configures the block through four registers in the user address space: enable, output enable, hold period and overflow policy. The block drives io_out/io_oeb for the low eight user pads.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base address; registers at BASE_ADDR + 0x00/0x04/0x08/0x0C.
PERIOD_W, 24, width of the hold-period register and timer.
DEFAULT_PERIOD, 24'd1000, reset value of PERIOD.

Ports:
wb_clk_i  in  1  single clock for all logic.
wb_rst_i  in  1  synchronous, active-high reset.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte-lane selects.
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
io_out  out  8  current sequence value a.
io_oeb  out  8  pad output enable, active low.

Behaviour:
- Registers (address decode on adr[31:4] == BASE_ADDR[31:4], offset adr[3:2]; all other addresses read 0, writes ignored, still acked):
  - 0x00 CTRL (RW): bit0 EN, bit1 OE, bit2 STOP_ON_OVF. Bit3 RESTART is write-1, self-clearing and reads 0.
  - 0x04 PERIOD (RW, [PERIOD_W-1:0]): cycles each value is held. A value of 0 behaves as 1.
  - 0x08 VALUE (RO): [7:0]=a, [15:8]=b, bit16 LAST, bit17 DONE.
  - 0x0C STEPS (RO): [15:0] count of advances since reset/RESTART; saturates at 16'hFFFF.
- Byte-lane writes honour wbs_sel_i.
- Wishbone timing:
  - wbs_ack_o is registered and asserts exactly one cycle after stb&cyc is seen with ack low.
  - Ack is high for one cycle and low the following cycle.
  - wbs_dat_o is valid while ack is high and 0 otherwise.
  - A write takes effect in the same edge that raises ack.
- Reset values: a=0, b=1, timer=0, LAST=0, DONE=0, STEPS=0, CTRL=0, PERIOD=DEFAULT_PERIOD, wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=8'hFF.
- Outputs: io_out=a at all times. io_oeb = OE ? 8'h00 : 8'hFF.
- Timer and advance:
  - Runs only while EN=1 and DONE=0. When EN=0, the timer, a and b freeze.
  - Timer counts 0..max(PERIOD,1)-1. At the terminal count, on the next edge: timer<=0, advance, STEPS+1.
  - The first value (0) is visible as soon as EN=1. The n-th advance completes n·P cycles after the EN write edge (P = max(PERIOD,1)).
- Advance, using a 9-bit sum s=a+b:
  - If LAST=0 and s≤255: a<=b, b<=s[7:0].
  - If LAST=0 and s>255: a<=b, LAST<=1, b unchanged. This is the step that shows 233.
  - If LAST=1 and STOP_ON_OVF=1: hold a=233, DONE<=1, no STEPS increment.
  - If LAST=1 and STOP_ON_OVF=0: wrap to a=0, b=1, LAST=0.
- Resulting sequence on a: 0,1,1,2,3,5,8,13,21,34,55,89,144,233.
- RESTART (or any CTRL write with bit3=1): a=0, b=1, timer=0, LAST=0, DONE=0, STEPS=0. RESTART wins over a coincident advance. The EN/OE/STOP bits from the same write still apply.
- PERIOD written mid-hold: the timer compares against the new value. If timer ≥ new P-1, the advance occurs on the next edge.
- wb_rst_i asserted mid-operation: every state returns to its reset value on the next edge, and any pending ack is dropped.

Test Plan:
1. Reset, then read all four registers -> CTRL=0, PERIOD=1000, VALUE=32'h0000_0100, STEPS=0; io_oeb=8'hFF, io_out=0.
2. Write PERIOD=4, then CTRL=3 -> io_oeb=0; io_out=5 after 20 cycles, 55 after 40, 144 after 48, 233 after 52 (cycles counted from the write edge); pin monitor sees 5→55→144 in order.
3. Same as 2 with CTRL=7 -> after 233, DONE=1 from cycle 56, io_out stays 233 for 100 further cycles, STEPS=13.
4. Same as 2 with STOP_ON_OVF=0 -> at cycle 56 io_out=0, then 1 at 60; LAST clears; STEPS=14.
5. Mid-run (io_out=21): write CTRL=4'hB -> next cycle io_out=0, STEPS=0, sequence restarts; back-to-back stb produces an ack only on alternating cycles; a sel=4'b0001 write of 32'hFFFF_FF02 to PERIOD changes only bits[7:0].
6. Assert wb_rst_i for one cycle while io_out=89 and ack is pending -> next cycle all values are at reset, wbs_ack_o=0, io_oeb=8'hFF.
